// File: rtl/wb_pkg.sv
// Shared widths and entry type for the register-file writeback path.
// The count width helper sizes occupancy counters that must represent 0..DEPTH inclusive.
package wb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_entry_queue.sv
// In-order circular buffer of late writeback results with per-entry live bits.
// A kill clears the live bit of every entry targeting a register; the live mask feeds decode stalls.
module wb_entry_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    input  logic                          kill,
    input  logic [REG_W-1:0]              kill_reg,
    output wb_entry_t                     head,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty,
    output logic                          full,
    output logic [NUM_REGS-1:0]           live_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [REG_W-1:0]  dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  live_reg;
    logic [DEPTH-1:0]  live_next;
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;

    // Payload needs no reset: an entry is only observed once its slot is occupied.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            dest_mem[tail_reg] <= push_entry.dest;
            data_mem[tail_reg] <= push_entry.data;
        end
    end

    // A freed slot drops its live bit so the mask only ever reflects occupied entries.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_live
            assign live_next[gi] =
                (push_ok && tail_reg == PW'(gi))       ? push_entry.live :
                (pop_ok && head_reg == PW'(gi))        ? 1'b0 :
                (kill && dest_mem[gi] == kill_reg)     ? 1'b0 :
                                                         live_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            live_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            live_reg <= live_next;
            if (push_ok) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop_ok) begin
                head_reg <= head_reg + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign head.live = live_reg[head_reg];
    assign head.dest = dest_mem[head_reg];
    assign head.data = data_mem[head_reg];

    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_reg[i]) begin
                live_mask[dest_mem[i]] = 1'b1;
            end
        end
        live_mask[0] = 1'b0;
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file write-port driver: single-cycle ALU writes take priority over queued late results.
// Late results that an ALU write overtakes are killed so the younger value is never overwritten.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          AluWrite,
    input  logic [REG_W-1:0]              AluWriteReg,
    input  logic [DATA_W-1:0]             AluWriteData,
    input  logic                          LateValid,
    output logic                          LateReady,
    input  logic [REG_W-1:0]              LateWriteReg,
    input  logic [DATA_W-1:0]             LateWriteData,
    output logic                          RegWrite,
    output logic [REG_W-1:0]              WriteReg,
    output logic [DATA_W-1:0]             WriteData,
    output logic [NUM_REGS-1:0]           PendingMask,
    output logic [count_width(DEPTH)-1:0] Count
);

    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic               transfer;
    logic               pop;
    logic               alu_kill;
    logic               empty;
    logic               full;

    logic               reg_write_reg;
    logic               reg_write_next;
    logic [REG_W-1:0]   write_reg_reg;
    logic [REG_W-1:0]   write_reg_next;
    logic [DATA_W-1:0]  write_data_reg;
    logic [DATA_W-1:0]  write_data_next;

    assign LateReady = !full;
    assign transfer  = LateValid && LateReady;
    assign alu_kill  = AluWrite && (AluWriteReg != '0);
    assign pop       = !AluWrite && !empty;

    // A same-cycle ALU write to the same register is younger, so the late entry is born dead.
    assign push_entry.live = (LateWriteReg != '0) &&
                             !(AluWrite && (AluWriteReg == LateWriteReg));
    assign push_entry.dest = LateWriteReg;
    assign push_entry.data = LateWriteData;

    wb_entry_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (Clock),
        .srst       (Reset),
        .push       (transfer),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (alu_kill),
        .kill_reg   (AluWriteReg),
        .head       (head),
        .count      (Count),
        .empty      (empty),
        .full       (full),
        .live_mask  (PendingMask)
    );

    always_comb begin
        reg_write_next  = 1'b0;
        write_reg_next  = write_reg_reg;
        write_data_next = write_data_reg;
        if (AluWrite) begin
            reg_write_next  = (AluWriteReg != '0);
            write_reg_next  = AluWriteReg;
            write_data_next = AluWriteData;
        end else if (!empty) begin
            // Killed heads still drain in order, just without a write strobe.
            reg_write_next  = head.live && (head.dest != '0);
            write_reg_next  = head.dest;
            write_data_next = head.data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            reg_write_reg  <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else begin
            reg_write_reg  <= reg_write_next;
            write_reg_reg  <= write_reg_next;
            write_data_reg <= write_data_next;
        end
    end

    assign RegWrite  = reg_write_reg;
    assign WriteReg  = write_reg_reg;
    assign WriteData = write_data_reg;

endmodule

// File: tb/tb_writeback_queue.sv
// Scenario bench for writeback_queue: expected register-file writes go into a scoreboard
// when stimulus is driven and are popped by a monitor whenever RegWrite is seen.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_write = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        late_valid = 1'b0;
    logic        late_ready;
    logic [4:0]  late_reg = '0;
    logic [31:0] late_data = '0;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .Clock         (clk),
        .Reset         (rst),
        .AluWrite      (alu_write),
        .AluWriteReg   (alu_reg),
        .AluWriteData  (alu_data),
        .LateValid     (late_valid),
        .LateReady     (late_ready),
        .LateWriteReg  (late_reg),
        .LateWriteData (late_data),
        .RegWrite      (reg_write),
        .WriteReg      (write_reg),
        .WriteData     (write_data),
        .PendingMask   (pending_mask),
        .Count         (count)
    );

    always #5 clk = ~clk;

    // Every asserted write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reg_write === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %h, required no write", write_reg, write_data);
            end else begin
                e = sb.pop_front();
                if (write_reg !== e.r || write_data !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got reg %0d data %h, required reg %0d data %h",
                             write_reg, write_data, e.r, e.d);
                end else begin
                    $display("write reg %0d data %h", write_reg, write_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_write  = 1'b0;
        late_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", reg_write); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d required 0", write_reg); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h required 0", write_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h required 0", pending_mask); end
        checks++; if (late_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", late_ready); end
        step();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL idle_we: got %b required 0", reg_write); end
        $display("test_reset done");
    endtask

    task automatic test_alu_write();
        alu_write = 1'b1; alu_reg = 5'd5; alu_data = 32'h0000_00AA;
        sb.push_back('{5'd5, 32'h0000_00AA});
        step();
        idle_inputs();
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL alu_we: got %b required 1", reg_write); end
        checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL alu_wreg: got %0d required 5", write_reg); end
        checks++; if (write_data !== 32'hAA) begin errors++; $display("FAIL alu_wdata: got %h required 000000aa", write_data); end
        alu_write = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
        step();
        idle_inputs();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL alu_r0_we: got %b required 0", reg_write); end
        checks++; if (write_data !== 32'h55) begin errors++; $display("FAIL alu_r0_wdata: got %h required 00000055", write_data); end
        $display("test_alu_write done");
    endtask

    task automatic test_late_latency();
        checks++; if (late_ready !== 1'b1) begin errors++; $display("FAIL late_ready_pre: got %b required 1", late_ready); end
        late_valid = 1'b1; late_reg = 5'd7; late_data = 32'h1234;
        sb.push_back('{5'd7, 32'h1234});
        step();
        idle_inputs();
        checks++; if (pending_mask !== 32'h80) begin errors++; $display("FAIL late_mask: got %h required 00000080", pending_mask); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL late_count: got %0d required 1", count); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL late_early_we: got %b required 0", reg_write); end
        step();
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h1234) begin
            errors++; $display("FAIL late_write: got we %b reg %0d data %h required we 1 reg 7 data 00001234",
                               reg_write, write_reg, write_data);
        end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL late_mask_clear: got %h required 0", pending_mask); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL late_count_clear: got %0d required 0", count); end
        $display("test_late_latency done");
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            checks++; if (late_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b required 1", i, late_ready); end
            alu_write = 1'b1; alu_reg = 5'd0; alu_data = 32'hDEAD;
            late_valid = 1'b1; late_reg = 5'(i); late_data = 32'h100 + 32'(i);
            step();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d required 4", count); end
        checks++; if (late_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b required 0", late_ready); end
        checks++; if (pending_mask !== 32'h1E) begin errors++; $display("FAIL fill_mask: got %h required 0000001e", pending_mask); end
        // Release the ALU while still offering a result: a full queue must refuse it despite the pop.
        alu_write = 1'b0;
        late_valid = 1'b1; late_reg = 5'd10; late_data = 32'hBAD;
        for (int i = 1; i <= 4; i++) sb.push_back('{5'(i), 32'h100 + 32'(i)});
        step();
        idle_inputs();
        checks++; if (late_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %b required 1", late_ready); end
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) step();
            checks++; if (reg_write !== 1'b1 || write_reg !== 5'(i)) begin
                errors++; $display("FAIL drain_%0d: got we %b reg %0d required we 1 reg %0d", i, reg_write, write_reg, i);
            end
            checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count_%0d: got %0d required %0d", i, count, 4 - i); end
        end
        step();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL fill_refused: got we %b reg %0d required 0", reg_write, write_reg); end
        $display("test_fill done");
    endtask

    task automatic test_kill();
        late_valid = 1'b1; late_reg = 5'd9; late_data = 32'h11;
        step();
        idle_inputs();
        checks++; if (pending_mask !== 32'h200) begin errors++; $display("FAIL kill_mask_set: got %h required 00000200", pending_mask); end
        alu_write = 1'b1; alu_reg = 5'd9; alu_data = 32'h22;
        sb.push_back('{5'd9, 32'h22});
        step();
        idle_inputs();
        checks++; if (reg_write !== 1'b1 || write_data !== 32'h22) begin
            errors++; $display("FAIL kill_alu_write: got we %b data %h required we 1 data 00000022", reg_write, write_data);
        end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL kill_mask_clear: got %h required 0", pending_mask); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL kill_count: got %0d required 1", count); end
        step();
        checks++; if (reg_write !== 1'b0 || write_data !== 32'h11) begin
            errors++; $display("FAIL kill_pop: got we %b data %h required we 0 data 00000011", reg_write, write_data);
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL kill_pop_count: got %0d required 0", count); end
        $display("test_kill done");
    endtask

    task automatic test_same_cycle();
        late_valid = 1'b1; late_reg = 5'd3; late_data = 32'h1;
        alu_write = 1'b1; alu_reg = 5'd3; alu_data = 32'h2;
        sb.push_back('{5'd3, 32'h2});
        step();
        idle_inputs();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL same_count: got %0d required 1", count); end
        checks++; if (pending_mask[3] !== 1'b0) begin errors++; $display("FAIL same_mask: got %b required 0", pending_mask[3]); end
        checks++; if (reg_write !== 1'b1 || write_data !== 32'h2) begin
            errors++; $display("FAIL same_alu: got we %b data %h required we 1 data 00000002", reg_write, write_data);
        end
        step();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL same_pop: got we %b required 0", reg_write); end
        // A late result to register 0 drains silently.
        late_valid = 1'b1; late_reg = 5'd0; late_data = 32'h77;
        step();
        idle_inputs();
        checks++; if (pending_mask !== 32'd0 || count !== 3'd1) begin
            errors++; $display("FAIL r0_late: got mask %h count %0d required mask 0 count 1", pending_mask, count);
        end
        step();
        checks++; if (reg_write !== 1'b0 || write_data !== 32'h77) begin
            errors++; $display("FAIL r0_pop: got we %b data %h required we 0 data 00000077", reg_write, write_data);
        end
        $display("test_same_cycle done");
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            alu_write = 1'b1; alu_reg = 5'd0; alu_data = 32'h0;
            late_valid = 1'b1; late_reg = 5'(12 + i); late_data = 32'hC0 + 32'(i);
            step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count_pre: got %0d required 3", count); end
        alu_write = 1'b0;
        late_valid = 1'b1; late_reg = 5'd15; late_data = 32'hF0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", count); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mid_we: got %b required 0", reg_write); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL mid_mask: got %h required 0", pending_mask); end
        step();
        checks++; if (reg_write !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL mid_lost: got we %b count %0d required we 0 count 0", reg_write, count);
        end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            late_valid = 1'b1; late_reg = 5'(16 + i); late_data = d;
            sb.push_back('{5'(16 + i), d});
            step();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count_%0d: got %0d required 1", i, count); end
            if (i > 0) begin
                checks++; if (reg_write !== 1'b1 || write_reg !== 5'(15 + i)) begin
                    errors++; $display("FAIL b2b_write_%0d: got we %b reg %0d required we 1 reg %0d", i, reg_write, write_reg, 15 + i);
                end
            end
        end
        idle_inputs();
        for (int n = 0; n < 20 && sb.size() != 0; n++) step();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d outstanding required 0", sb.size()); end
        step();
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_late_latency();
        test_fill();
        test_kill();
        test_same_cycle();
        test_reset_mid_drain();
        test_back_to_back();
        step();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d outstanding required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
